sample_expand: RTL
==================

Name: sample_expand

Overview:
- Display-side reader for the sampled grid produced by the CCD sampling stage. The sampler writes 1-bit samples into a 32x24 grid.
- The block stores that grid and expands each sample to a 20x20 pixel cell on the 640x480 VGA raster.
- Double-buffered: the display never shows a partially written grid.
- Sits between the sampler output and the VGA colour mux.

Parameters:
- GRID_COLS, 32, sample columns (5-bit index)
- GRID_ROWS, 24, sample rows (5-bit index)
- CELL, 20, display pixels per sample cell, both axes
- H_ACT, 640, active display width
- V_ACT, 480, active display height

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_wr  in  1  sample write strobe
- s_srow_cont  in  5  sample row index
- s_scol_cont  in  5  sample column index
- s_bit  in  1  sample value
- s_done  in  1  one-cycle pulse: sampler finished a full grid
- d_valid  in  1  display coordinate valid (active video)
- d_icol_cont  in  10  display x coordinate
- d_irow_cont  in  10  display y coordinate
- opixel  out  1  expanded pixel value
- o_valid  out  1  opixel qualifies d_valid delayed by 2 cycles
- rbank  out  1  bank currently displayed (debug/visibility)

Behaviour:
- Storage: two banks of GRID_COLS*GRID_ROWS bits, address = row*GRID_COLS + col. Write bank wbank is always ~rbank.
- Reset (asynchronous, reset_n=0): rbank=0, pending_swap=0, all pipeline valids=0, opixel=0, o_valid=0, all bitmap bits=0.
- Write: on clk with s_wr=1, bank[wbank][addr] <= s_bit.
  - Writes with s_srow_cont>=GRID_ROWS or s_scol_cont>=GRID_COLS are dropped; no wrap.
  - Writes never touch rbank.
- Swap request: s_done=1 sets pending_swap. Repeated s_done before a swap is idempotent.
- Swap point: the cycle with d_valid=1, d_icol_cont=H_ACT-1 and d_irow_cont=V_ACT-1.
  - If pending_swap, or s_done in the same cycle, then rbank toggles and pending_swap clears at that edge.
  - An s_done coincident with the swap point is consumed by that swap; pending_swap stays 0.
  - An s_wr coincident with the swap point targets the pre-toggle wbank.
- Display pipeline, fixed latency 2:
  - Stage 1: if d_valid, compute ccol = (x*RECIP)>>16 and crow = (y*RECIP)>>16, with RECIP=3277. Register ccol/crow/valid. Out-of-range coordinates (x>=H_ACT or y>=V_ACT) clear valid.
  - Stage 2: opixel <= valid ? bank[rbank_at_stage1][crow*GRID_COLS+ccol] : 0; o_valid <= valid.
  - rbank is sampled into stage 1, so a swap never changes the bank mid-pixel.
- No backpressure: one coordinate per cycle accepted; gaps (d_valid=0) propagate as o_valid=0, opixel=0.
- Arithmetic: products are 22 bits. RECIP division is exact for all 0<=x<640 with CELL=20.
- Reset asserted mid-frame: pipeline flushes to 0, pending swap is lost, grid contents clear.

Decomposition:
- Shared package sample_pkg: GRID_COLS, GRID_ROWS, CELL, H_ACT, V_ACT, RECIP, RECIP_SHIFT=16, typedef cell_idx_t (logic [4:0]), typedef grid_addr_t (logic [9:0]).
- One sub-module: sample_bitmap_2bank (dual-bank bit storage; 1 write port, 1 registered read port, bank-select inputs).
- Pipeline control and swap logic stay in sample_expand.

Test Plan:
- Reset: hold reset_n=0 with d_valid=1 -> opixel=0, o_valid=0, rbank=0. Release -> first o_valid appears exactly 2 cycles after the first d_valid.
- Write (row 3, col 5)=1 into bank 1, s_done, run to swap point -> rbank=1 the next cycle. Pixels x=100..119, y=60..79 -> opixel=1; x=99 and x=120 -> 0.
- Cell boundaries: bank with col 31/row 23 =1 after swap -> x=620..639, y=460..479 give 1; x=619 gives 0. No wrap to col 0.
- Writes without s_done across 2 frames -> rbank unchanged, displayed image unchanged. s_done and swap point in the same cycle -> swap happens, pending_swap=0 afterwards.
- s_wr to (24,0) and (0,31) with s_bit=1 -> (24,0) dropped; (0,31) appears at x=620..639, y=0..19 after swap.
- Assert reset_n=0 mid-line with pending_swap=1 -> outputs 0 asynchronously, rbank=0, no swap at next swap point.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared constants, types and index helpers for the sample-grid expander.
// The grid is 32x24 one-bit samples; each maps to a 20x20 pixel cell on 640x480.
package sample_pkg;

    localparam int GRID_COLS   = 32;
    localparam int GRID_ROWS   = 24;
    localparam int CELL        = 20;
    localparam int H_ACT       = 640;
    localparam int V_ACT       = 480;
    localparam int RECIP       = 3277;
    localparam int RECIP_SHIFT = 16;
    localparam int GRID_CELLS  = GRID_COLS * GRID_ROWS;

    typedef logic [4:0]  cell_idx_t;
    typedef logic [9:0]  grid_addr_t;
    typedef logic [9:0]  coord_t;
    typedef logic [21:0] prod_t;

    // (c * 3277) >> 16 equals c / 20 for every on-screen coordinate.
    function automatic cell_idx_t coord_to_cell(input coord_t c);
        prod_t p;
        p = prod_t'(c) * prod_t'(RECIP);
        return cell_idx_t'(p >> RECIP_SHIFT);
    endfunction

    function automatic grid_addr_t grid_addr(input cell_idx_t row, input cell_idx_t col);
        return grid_addr_t'(int'(row) * GRID_COLS + int'(col));
    endfunction

endpackage

// File: rtl/sample_expand_if.sv
// Sampler-write, display-coordinate and expanded-pixel signals of sample_expand.
// master drives samples and coordinates; slave (the expander) returns pixels.
interface sample_expand_if;
    import sample_pkg::*;

    logic      s_wr;
    cell_idx_t s_srow_cont;
    cell_idx_t s_scol_cont;
    logic      s_bit;
    logic      s_done;
    logic      d_valid;
    coord_t    d_icol_cont;
    coord_t    d_irow_cont;
    logic      opixel;
    logic      o_valid;
    logic      rbank;

    modport master (
        output s_wr, s_srow_cont, s_scol_cont, s_bit, s_done,
        output d_valid, d_icol_cont, d_irow_cont,
        input  opixel, o_valid, rbank
    );

    modport slave (
        input  s_wr, s_srow_cont, s_scol_cont, s_bit, s_done,
        input  d_valid, d_icol_cont, d_irow_cont,
        output opixel, o_valid, rbank
    );

endinterface

// File: rtl/sample_bitmap_2bank.sv
// Two banks of one-bit grid storage: one write port, one registered read port.
// Banks are flop arrays because reset must clear every stored sample.
module sample_bitmap_2bank
    import sample_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic       wr_bank,
    input  grid_addr_t wr_addr,
    input  logic       wr_data,
    input  logic       rd_en,
    input  logic       rd_bank,
    input  grid_addr_t rd_addr,
    output logic       rd_data
);

    logic [GRID_CELLS-1:0] bank_bits [2];
    logic                  rd_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [GRID_CELLS-1:0] mem_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mem_reg <= '0;
                end else if (wr_en && (wr_bank == 1'(gi))) begin
                    mem_reg[wr_addr] <= wr_data;
                end
            end

            assign bank_bits[gi] = mem_reg;
        end
    endgenerate

    // Idle read slots return 0 so gaps in the raster stay dark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_reg <= 1'b0;
        end else begin
            rd_data_reg <= rd_en ? bank_bits[rd_bank][rd_addr] : 1'b0;
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/sample_expand.sv
// Double-buffered 32x24 sample grid expanded onto the 640x480 raster.
// Two-stage display pipeline; banks swap only at the last active pixel of a frame.
module sample_expand
    import sample_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    sample_expand_if.slave  bus
);

    logic       rbank_reg, rbank_next;
    logic       pending_swap_reg, pending_swap_next;
    logic       swap_point;
    logic       wr_ok;

    logic       s1_valid_reg, s1_valid_next;
    cell_idx_t  s1_ccol_reg, s1_ccol_next;
    cell_idx_t  s1_crow_reg, s1_crow_next;
    logic       s1_bank_reg;
    logic       o_valid_reg;
    logic       rd_pixel;

    assign swap_point = bus.d_valid
                     && (bus.d_icol_cont == coord_t'(H_ACT - 1))
                     && (bus.d_irow_cont == coord_t'(V_ACT - 1));

    // Indices are widened so the 32-column limit is representable.
    assign wr_ok = bus.s_wr
                && ({1'b0, bus.s_srow_cont} < 6'(GRID_ROWS))
                && ({1'b0, bus.s_scol_cont} < 6'(GRID_COLS));

    always_comb begin
        rbank_next        = rbank_reg;
        pending_swap_next = pending_swap_reg;
        if (swap_point && (pending_swap_reg || bus.s_done)) begin
            rbank_next        = ~rbank_reg;
            pending_swap_next = 1'b0;
        end else if (bus.s_done) begin
            pending_swap_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rbank_reg        <= 1'b0;
            pending_swap_reg <= 1'b0;
        end else begin
            rbank_reg        <= rbank_next;
            pending_swap_reg <= pending_swap_next;
        end
    end

    always_comb begin
        s1_valid_next = bus.d_valid
                     && (bus.d_icol_cont < coord_t'(H_ACT))
                     && (bus.d_irow_cont < coord_t'(V_ACT));
        s1_ccol_next  = coord_to_cell(bus.d_icol_cont);
        s1_crow_next  = coord_to_cell(bus.d_irow_cont);
    end

    // The display bank is captured with the coordinate, so a swap landing
    // between the stages cannot change which bank this pixel reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_ccol_reg  <= '0;
            s1_crow_reg  <= '0;
            s1_bank_reg  <= 1'b0;
            o_valid_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s1_ccol_reg  <= s1_ccol_next;
            s1_crow_reg  <= s1_crow_next;
            s1_bank_reg  <= rbank_reg;
            o_valid_reg  <= s1_valid_reg;
        end
    end

    sample_bitmap_2bank u_bitmap (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_ok),
        .wr_bank (~rbank_reg),
        .wr_addr (grid_addr(bus.s_srow_cont, bus.s_scol_cont)),
        .wr_data (bus.s_bit),
        .rd_en   (s1_valid_reg),
        .rd_bank (s1_bank_reg),
        .rd_addr (grid_addr(s1_crow_reg, s1_ccol_reg)),
        .rd_data (rd_pixel)
    );

    assign bus.opixel  = rd_pixel;
    assign bus.o_valid = o_valid_reg;
    assign bus.rbank   = rbank_reg;

endmodule
